squeeze_output: RTL



---
 rtl/squeeze_output_if.sv | 55 +++++
 rtl/squeeze_output.sv | 111 +++++++++++
 2 files changed

// File: rtl/squeeze_output_if.sv
`default_nettype none
// ============================================================================
//  Module      : squeeze_output_if
//  Description : Host-side bundle of the SHA3-512 squeeze stage. It carries
//                the sponge state input, the go/kill controls, the byte
//                stream handshake and the progress/status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface squeeze_output_if;

   // Sponge state after the final permutation
   logic [1599:0] state_in;

   // Control
   logic          go;
   logic          kill;

   // Byte stream (valid/ready)
   logic [7:0]    dataOut;
   logic          dataValid;
   logic          dataRD;

   // Progress and status
   logic [6:0]    count;
   logic          busy;
   logic          done;

   // Host side: drives state and controls, consumes the byte stream
   modport master (
      output state_in,
      output go,
      output kill,
      output dataRD,
      input  dataOut,
      input  dataValid,
      input  count,
      input  busy,
      input  done
   );

   // Squeeze stage side
   modport slave (
      input  state_in,
      input  go,
      input  kill,
      input  dataRD,
      output dataOut,
      output dataValid,
      output count,
      output busy,
      output done
   );

endinterface
`default_nettype wire

// File: rtl/squeeze_output.sv
`default_nettype none
// ============================================================================
//  Module      : squeeze_output
//  Description : Squeeze stage of the SHA3-512 core. Captures the low
//                DIGEST_BYTES bytes of the sponge state when go is accepted
//                and streams them out one byte per accepted transfer,
//                least-significant byte of lane 0 first. kill aborts the
//                squeeze synchronously; rst clears everything asynchronously.
//  Revision    : 1.0 - initial release
// ============================================================================
module squeeze_output #(
   parameter int DIGEST_BYTES = 64
) (
   input  wire logic       clk,
   input  wire logic       rst,
   squeeze_output_if.slave bus
);

   // Width of the digest shift register
   localparam int c_shift_w = 8 * DIGEST_BYTES;

   // Value of count just before the final transfer
   localparam logic [6:0] c_last_count = 7'(DIGEST_BYTES - 1);

   // LOAD is folded into the IDLE->SEND edge, so only three states exist
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                 r_state;
   logic [c_shift_w-1:0]   r_shift;
   logic [6:0]             r_count;
   logic                   r_valid;
   logic                   r_busy;
   logic                   r_done;

   // A transfer happens when a byte is presented and the consumer is ready
   logic                   w_xfer;
   assign w_xfer = r_valid & bus.dataRD;

   // Controller: state, digest shift register, byte counter and status flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_count <= 7'd0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (bus.kill) begin
         // Abort wins over any handshake or start in this cycle
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_count <= 7'd0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (bus.go) begin
                  // Only the digest lanes are kept; upper state bits are dropped
                  r_shift <= bus.state_in[c_shift_w-1:0];
                  r_count <= 7'd0;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (w_xfer) begin
                  // Next byte moves into the low lane; zeros fill from the top
                  r_shift <= r_shift >> 8;
                  r_count <= r_count + 7'd1;
                  if (r_count == c_last_count) begin
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               // go is deliberately ignored here; a new squeeze starts from IDLE
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_shift <= '0;
               r_count <= 7'd0;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // All outputs come straight from registers
   assign bus.dataOut   = r_shift[7:0];
   assign bus.dataValid = r_valid;
   assign bus.count     = r_count;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;

endmodule
`default_nettype wire
